// File: rtl/cska_pipe.sv
// cska_pipe: parametrised, pipelined carry-skip adder/subtractor.
//
// The WIDTH-bit operands are cut into STAGES equal slices. Slice k is summed
// in pipeline stage k by a carry-skip chain of BLOCK-bit groups, using the
// carry registered by stage k-1 (stage 0 uses the effective carry-in).
// Operand bits not yet consumed ride along in each stage register, shrinking
// by one slice per stage.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready depends only on output side)
//   operA, operB, Cin    operands and carry-in (borrow-in when sub=1)
//   sub                  0 = A + B + Cin, 1 = A - B - Cin
//   out_valid/out_ready  result handshake
//   resultOUT, Cout, Ovf sum/difference, raw MSB carry, signed overflow

module cska_slice #(
    parameter int SW    = 16,
    parameter int BLOCK = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          ci,
    output logic [SW-1:0] s,
    output logic          co
);
    localparam int NG = SW / BLOCK;

    for (genvar g = 0; g < NG; g++) begin : g_grp
        logic [BLOCK-1:0] ga, gb, p;
        logic [BLOCK:0]   rc;
        logic             gci, gco;

        if (g == 0) begin : g_cin
            assign gci = ci;
        end else begin : g_cchain
            assign gci = g_grp[g-1].gco;
        end

        assign ga    = a[g*BLOCK +: BLOCK];
        assign gb    = b[g*BLOCK +: BLOCK];
        assign p     = ga ^ gb;
        assign rc[0] = gci;
        for (genvar i = 0; i < BLOCK; i++) begin : g_bit
            assign rc[i+1] = (ga[i] & gb[i]) | (p[i] & rc[i]);
        end
        assign s[g*BLOCK +: BLOCK] = p ^ rc[BLOCK-1:0];
        // Skip mux: a fully propagating group forwards its carry-in directly,
        // bypassing the ripple chain on the critical path.
        assign gco = (&p) ? gci : rc[BLOCK];
    end

    assign co = g_grp[NG-1].gco;
endmodule

module cska_pipe #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operA,
    input  logic [WIDTH-1:0] operB,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] resultOUT,
    output logic             Cout,
    output logic             Ovf
);
    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || BLOCK < 1 || (WIDTH % STAGES) != 0 || (SW % BLOCK) != 0) begin : g_bad_cfg
        $error("cska_pipe: WIDTH must split into STAGES slices that are multiples of BLOCK");
    end

    logic stall;

    // The whole pipeline freezes when the final result is blocked.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int IW = WIDTH - k*SW;   // operand bits still to consume
        localparam int RW = (k+1)*SW;       // result bits known after this stage

        logic [IW-1:0] a_in, b_in;
        logic          ci, v_in;
        logic [SW-1:0] s;
        logic          co;
        logic [RW-1:0] r_d, r_q;
        logic          vld_q, cy_q;

        if (k == 0) begin : g_head
            assign a_in = operA;
            assign b_in = operB ^ {WIDTH{sub}};
            assign ci   = Cin ^ sub;
            assign v_in = in_valid;
            assign r_d  = s;
        end else begin : g_tail
            assign a_in = g_st[k-1].g_fwd.a_q;
            assign b_in = g_st[k-1].g_fwd.b_q;
            assign ci   = g_st[k-1].cy_q;
            assign v_in = g_st[k-1].vld_q;
            assign r_d  = {s, g_st[k-1].r_q};
        end

        cska_slice #(.SW(SW), .BLOCK(BLOCK)) u_slice (
            .a  (a_in[SW-1:0]),
            .b  (b_in[SW-1:0]),
            .ci (ci),
            .s  (s),
            .co (co)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                r_q   <= '0;
            end else if (!stall) begin
                vld_q <= v_in;
                cy_q  <= co;
                r_q   <= r_d;
            end
        end

        if (k < STAGES-1) begin : g_fwd
            // Upper operand slices (including both MSBs for Ovf) carried forward.
            logic [IW-SW-1:0] a_q, b_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_in[IW-1:SW];
                    b_q <= b_in[IW-1:SW];
                end
            end
        end else begin : g_ovf
            logic ovf_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= (a_in[IW-1] == b_in[IW-1]) && (s[SW-1] != a_in[IW-1]);
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign resultOUT = g_st[STAGES-1].r_q;
    assign Cout      = g_st[STAGES-1].cy_q;
    assign Ovf       = g_st[STAGES-1].g_ovf.ovf_q;
endmodule

// File: tb/tb_cska_pipe.sv
module tb_cska_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, Ovf;
    logic [31:0] operA, operB, resultOUT;

    logic        in_valid_w, in_ready_w, Cin_w, sub_w, out_valid_w, out_ready_w, Cout_w, Ovf_w;
    logic [63:0] operA_w, operB_w, resultOUT_w;

    int n_checks = 0;
    int n_fail   = 0;

    cska_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operA(operA), .operB(operB), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .resultOUT(resultOUT), .Cout(Cout), .Ovf(Ovf)
    );

    cska_pipe #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .operA(operA_w), .operB(operB_w), .Cin(Cin_w), .sub(sub_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w),
        .resultOUT(resultOUT_w), .Cout(Cout_w), .Ovf(Ovf_w)
    );

    // Directed vectors: A, B, Cin, sub -> result, Cout, Ovf (hand computed).
    localparam int NV = 8;
    logic [31:0] va [NV] = '{32'hFFFFFFFF, 32'hAAAAAAAA, 32'h7FFFFFFF, 32'h00000005,
                             32'h00000009, 32'h80000000, 32'h12345678, 32'h0000FFFF};
    logic [31:0] vb [NV] = '{32'h00000001, 32'h55555555, 32'h00000001, 32'h00000007,
                             32'h00000003, 32'h00000001, 32'h11111111, 32'h00000001};
    logic        vc [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        vs [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] vr [NV] = '{32'h00000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFE,
                             32'h00000005, 32'h7FFFFFFF, 32'h23456789, 32'h00010000};
    logic        vco[NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        vov[NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // All tasks start and end 1 time unit after a rising edge.
    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; operA = 32'h1; operB = 32'h2; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_valid_w !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: out_valid=%b in_ready=%b out_valid_w=%b, want 0 1 0", out_valid, in_ready, out_valid_w);
        end
        n_checks++;
        if ({resultOUT, Cout, Ovf} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: result=%h Cout=%b Ovf=%b, want all zero", resultOUT, Cout, Ovf);
        end
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_discard: out_valid=%b, want 0", out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_vectors;
        for (int i = 0; i < NV; i++) begin
            operA = va[i]; operB = vb[i]; Cin = vc[i]; sub = vs[i];
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk); #1 in_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_early: out_valid=%b one cycle after accept, want 0", i, out_valid);
            end
            @(posedge clk); #1;
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || resultOUT !== vr[i] || Cout !== vco[i] || Ovf !== vov[i]) begin
                n_fail++;
                $display("FAIL vec%0d: valid=%b result=%h Cout=%b Ovf=%b, want 1 %h %b %b",
                         i, out_valid, resultOUT, Cout, Ovf, vr[i], vco[i], vov[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_r [6];
        int sent = 0, got = 0, hold = 0;
        bit held_once = 0;
        for (int i = 0; i < 6; i++) exp_r[i] = 32'h00010000 + i;
        Cin = 1'b0; sub = 1'b0; operB = 32'h1;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            in_valid = (sent < 6);
            operA = 32'h0000FFFF + sent;
            out_ready = (hold == 0);
            if (hold > 0) hold--;
            @(negedge clk);
            if (out_valid && !out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0 || resultOUT !== exp_r[got] || Cout !== 1'b0 || Ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold: in_ready=%b result=%h Cout=%b Ovf=%b, want 0 %h 0 0",
                             in_ready, resultOUT, Cout, Ovf, exp_r[got]);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (got >= 6 || resultOUT !== exp_r[got]) begin
                    n_fail++;
                    $display("FAIL bp_order: result %0d=%h, want %h", got, resultOUT, exp_r[got % 6]);
                end
                got++;
                if (!held_once) begin held_once = 1; hold = 4; end
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (got != 6 || sent != 6) begin
            n_fail++;
            $display("FAIL bp_count: sent=%0d delivered=%0d, want 6 6", sent, got);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_dup: out_valid=%b after drain, want 0", out_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_inflight;
        out_ready = 1'b0; in_valid = 1'b1; Cin = 1'b0; sub = 1'b0;
        operA = 32'h1; operB = 32'h2;
        @(posedge clk); #1 operA = 32'h3; operB = 32'h4;
        @(posedge clk); #1 rst = 1'b1; operA = 32'h5;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || resultOUT !== 32'h3) begin
            n_fail++;
            $display("FAIL rst_inflight_pre: out_valid=%b result=%h, want 1 00000003", out_valid, resultOUT);
        end
        @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || resultOUT !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_inflight: out_valid=%b in_ready=%b result=%h, want 0 1 0", out_valid, in_ready, resultOUT);
        end
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_stale: out_valid=%b result=%h after reset, want 0", out_valid, resultOUT);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sweep64;
        localparam int NOPS = 2000;
        logic [65:0] q[$];
        logic [65:0] e;
        logic [63:0] be;
        logic [64:0] s;
        logic        ov;
        int sent = 0, got = 0;
        for (int cyc = 0; cyc < 20000 && got < NOPS; cyc++) begin
            in_valid_w  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
            operA_w     = {$urandom, $urandom};
            operB_w     = ($urandom_range(0, 7) == 0) ? ~operA_w : {$urandom, $urandom};
            Cin_w       = 1'($urandom_range(0, 1));
            sub_w       = 1'($urandom_range(0, 1));
            out_ready_w = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid_w && out_ready_w) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sweep64_extra: result %h with nothing outstanding", resultOUT_w);
                end else begin
                    e = q.pop_front();
                    if ({Ovf_w, Cout_w, resultOUT_w} !== e) begin
                        n_fail++;
                        $display("FAIL sweep64 op%0d: result=%h Cout=%b Ovf=%b, want %h %b %b",
                                 got, resultOUT_w, Cout_w, Ovf_w, e[63:0], e[64], e[65]);
                    end
                end
                got++;
            end
            if (in_valid_w && in_ready_w) begin
                be = operB_w ^ {64{sub_w}};
                s  = {1'b0, operA_w} + {1'b0, be} + 65'(Cin_w ^ sub_w);
                ov = (operA_w[63] == be[63]) && (s[63] != operA_w[63]);
                q.push_back({ov, s});
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid_w = 1'b0; out_ready_w = 1'b1;
        n_checks++;
        if (got != NOPS) begin
            n_fail++;
            $display("FAIL sweep64_count: delivered=%0d, want %0d", got, NOPS);
        end
    endtask

    initial begin
        in_valid = 1'b0; operA = '0; operB = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid_w = 1'b0; operA_w = '0; operB_w = '0; Cin_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        test_reset;
        test_vectors;
        test_backpressure;
        test_reset_inflight;
        test_sweep64;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
